// File: rtl/sound_arbiter_pkg.sv
// Shared types and constants for the sound arbiter: FSM states, timer width
// and the clocks-per-duration-unit helper.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam int DUR_W   = 5;
  localparam int TIMER_W = 32;

  function automatic logic [TIMER_W-1:0] ticks_per_unit(input int clk_hz, input int dur_div);
    return TIMER_W'(clk_hz / dur_div);
  endfunction

endpackage

// File: rtl/sound_arbiter_note_timer.sv
// Loadable down-counter that times one note; expired is high on the last
// cycle of the note (a zero load expires immediately).
module note_timer
  import sound_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign expired = (count <= TIMER_W'(1));

endmodule

// File: rtl/sound_arbiter.sv
// Fixed-priority owner of the note ROM and tone generator: picks a pending
// requester, walks its note sheet and times each note.
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CLK_HZ   = 130_000_000,
  parameter int DUR_DIV  = 16,
  parameter int PERIOD_W = 20,
  parameter int IDX_W    = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         cancel,
  output logic [$clog2(NUM_REQ)-1:0] sheet_sel,
  output logic [IDX_W-1:0]           sheet_number,
  input  logic [PERIOD_W-1:0]        sheet_period,
  input  logic [DUR_W-1:0]           sheet_duration,
  input  logic                       sheet_done,
  output logic [PERIOD_W-1:0]        tone_period,
  output logic                       tone_en,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic [NUM_REQ-1:0]         done_pulse,
  output state_t                     fsm_state
);

  localparam int                 SEL_W = $clog2(NUM_REQ);
  localparam logic [TIMER_W-1:0] TICKS = ticks_per_unit(CLK_HZ, DUR_DIV);

  state_t               state, state_next;
  logic [SEL_W-1:0]     sel_next;
  logic [IDX_W-1:0]     number_next;
  logic [PERIOD_W-1:0]  period_next;
  logic [NUM_REQ-1:0]   pend, pend_next;
  logic [NUM_REQ-1:0]   done_next;
  logic [NUM_REQ-1:0]   req_eff, arb_vec, low_mask;
  logic [SEL_W-1:0]     arb_idx;
  logic                 arb_any, lower_pend, owner_cancel;
  logic                 timer_load, timer_expired;
  logic [TIMER_W-1:0]   timer_value;

  note_timer u_note_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  assign timer_value = TIMER_W'(sheet_duration) * TICKS;

  always_comb begin
    state_next   = state;
    sel_next     = sheet_sel;
    number_next  = sheet_number;
    period_next  = tone_period;
    done_next    = '0;
    timer_load   = 1'b0;
    arb_any      = 1'b0;
    arb_idx      = '0;
    low_mask     = '0;
    owner_cancel = cancel[sheet_sel] && (state != IDLE);

    // A repeat request from the owner while it plays must not restart it.
    req_eff = req;
    if (state != IDLE) req_eff[sheet_sel] = 1'b0;
    pend_next = (pend | req_eff) & ~cancel;

    // Lowest set index wins; a same-cycle cancel withdraws the request.
    arb_vec = pend & ~cancel;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (arb_vec[i]) begin
        arb_any = 1'b1;
        arb_idx = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) low_mask[i] = (i < int'(sheet_sel));
    lower_pend = |(arb_vec & low_mask);

    case (state)
      IDLE: begin
        if (arb_any) begin
          state_next         = LOAD;
          sel_next           = arb_idx;
          number_next        = '0;
          pend_next[arb_idx] = 1'b0;
        end
      end
      LOAD: begin
        if (owner_cancel) begin
          state_next = IDLE;
        end else if (sheet_done) begin
          state_next           = IDLE;
          done_next[sheet_sel] = 1'b1;
        end else begin
          period_next = sheet_period;
          timer_load  = 1'b1;
          state_next  = PLAY;
        end
      end
      PLAY: begin
        if (owner_cancel) begin
          state_next = IDLE;
        end else if (timer_expired) begin
          state_next = LOAD;
          if (lower_pend) begin
            sel_next           = arb_idx;
            number_next        = '0;
            pend_next[arb_idx] = 1'b0;
          end else begin
            number_next = sheet_number + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      sheet_sel    <= '0;
      sheet_number <= '0;
      tone_period  <= '0;
      pend         <= '0;
      done_pulse   <= '0;
    end else begin
      state        <= state_next;
      sheet_sel    <= sel_next;
      sheet_number <= number_next;
      tone_period  <= period_next;
      pend         <= pend_next;
      done_pulse   <= done_next;
    end
  end

  assign busy      = (state != IDLE);
  assign tone_en   = (state == PLAY) && (tone_period != '0);
  assign grant     = busy ? (NUM_REQ'(1) << sheet_sel) : '0;
  assign fsm_state = state;

endmodule

// File: tb/tb_sound_arbiter.sv
// Bench for sound_arbiter: every change of the observed outputs is matched
// against a queue of hand-computed (cycle, outputs) events.
module tb_sound_arbiter;
  import sound_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int CLK_HZ   = 1600;
  localparam int DUR_DIV  = 16;
  localparam int PERIOD_W = 20;
  localparam int IDX_W    = 10;
  localparam int OBS_W    = 40;
  localparam int EV_W     = 32 + OBS_W;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic [3:0]          req = '0;
  logic [3:0]          cancel = '0;
  logic [1:0]          sheet_sel;
  logic [IDX_W-1:0]    sheet_number;
  logic [PERIOD_W-1:0] sheet_period;
  logic [DUR_W-1:0]    sheet_duration;
  logic                sheet_done;
  logic [PERIOD_W-1:0] tone_period;
  logic                tone_en;
  logic [3:0]          grant;
  logic                busy;
  logic [3:0]          done_pulse;
  state_t              fsm_state;

  sound_arbiter #(
    .NUM_REQ (NUM_REQ),
    .CLK_HZ  (CLK_HZ),
    .DUR_DIV (DUR_DIV),
    .PERIOD_W(PERIOD_W),
    .IDX_W   (IDX_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .cancel        (cancel),
    .sheet_sel     (sheet_sel),
    .sheet_number  (sheet_number),
    .sheet_period  (sheet_period),
    .sheet_duration(sheet_duration),
    .sheet_done    (sheet_done),
    .tone_period   (tone_period),
    .tone_en       (tone_en),
    .grant         (grant),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required test completion", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- note sheet ROM model ----------------
  // seq0 {(30,1),done}  seq1 {(50,2),(0,1),done}  seq2 {done}  seq3 {(70,3),(80,1),done}
  always_comb begin
    sheet_period   = '0;
    sheet_duration = '0;
    sheet_done     = 1'b1;
    case (sheet_sel)
      2'd0: if (sheet_number == 10'd0) begin
        sheet_period = 20'd30; sheet_duration = 5'd1; sheet_done = 1'b0;
      end
      2'd1: if (sheet_number == 10'd0) begin
        sheet_period = 20'd50; sheet_duration = 5'd2; sheet_done = 1'b0;
      end else if (sheet_number == 10'd1) begin
        sheet_period = 20'd0; sheet_duration = 5'd1; sheet_done = 1'b0;
      end
      2'd3: if (sheet_number == 10'd0) begin
        sheet_period = 20'd70; sheet_duration = 5'd3; sheet_done = 1'b0;
      end else if (sheet_number == 10'd1) begin
        sheet_period = 20'd80; sheet_duration = 5'd1; sheet_done = 1'b0;
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [EV_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en      = 1'b0;
  logic rst_chk_req = 1'b0;
  logic rst_chk_done = 1'b0;
  int drain_req  = 0;
  int drain_seen = 0;

  function automatic logic [OBS_W-1:0] pack(input logic [3:0] g, input logic b, input logic en,
                                            input logic [19:0] p, input logic [9:0] n,
                                            input logic [3:0] d);
    return {g, b, en, p, n, d};
  endfunction

  task automatic expect_ev(input int c, input logic [3:0] g, input logic b, input logic en,
                           input int p, input int n, input logic [3:0] d);
    logic [31:0] cc;
    cc = c;
    exp_q.push_back({cc, pack(g, b, en, p[19:0], n[9:0], d)});
  endtask

  // Monitor: the only writer of the counters.
  logic [OBS_W-1:0] obs, prev_obs;
  logic [EV_W-1:0]  exp_ev;
  logic [31:0]      cyc_w;
  initial prev_obs = '0;

  always @(negedge clock) begin
    obs   = pack(grant, busy, tone_en, tone_period, sheet_number, done_pulse);
    cyc_w = cyc;
    if (rst_chk_req && !rst_chk_done) begin
      rst_chk_done = 1'b1;
      n_checks++;
      if (obs !== '0 || fsm_state !== IDLE) begin
        n_fail++;
        $display("FAIL reset_state: got outputs=%h state=%0d, required 0 and IDLE", obs, fsm_state);
      end
    end
    if (!mon_en) begin
      prev_obs = obs;
    end else if (obs !== prev_obs) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: cycle %0d outputs=%h (was %h), required no change",
                 cyc, obs, prev_obs);
      end else begin
        exp_ev = exp_q.pop_front();
        if ({cyc_w, obs} !== exp_ev) begin
          n_fail++;
          $display("FAIL event: got cycle %0d g=%b busy=%b en=%b per=%0d num=%0d done=%b, required cycle %0d g=%b busy=%b en=%b per=%0d num=%0d done=%b",
                   cyc, obs[39:36], obs[35], obs[34], obs[33:14], obs[13:4], obs[3:0],
                   exp_ev[71:40], exp_ev[39:36], exp_ev[35], exp_ev[34], exp_ev[33:14],
                   exp_ev[13:4], exp_ev[3:0]);
        end
      end
      prev_obs = obs;
    end
    if (drain_req != drain_seen) begin
      drain_seen = drain_req;
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expected events never seen by cycle %0d, required 0",
                 exp_q.size(), cyc);
        exp_q.delete();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic pulse_req(input logic [3:0] m);
    req = m;
    @(negedge clock);
    req = '0;
  endtask

  task automatic pulse_cancel(input logic [3:0] m);
    cancel = m;
    @(negedge clock);
    cancel = '0;
  endtask

  task automatic drain();
    drain_req++;
    @(negedge clock);
    @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  int b;
  initial begin
    repeat (3) @(negedge clock);
    rst_chk_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clock);

    // 1: seq1 plays (50,2) then a rest (0,1), then completes
    b = cyc;
    expect_ev(b + 2,   4'b0010, 1, 0, 0,  0, 4'b0000);
    expect_ev(b + 3,   4'b0010, 1, 1, 50, 0, 4'b0000);
    expect_ev(b + 203, 4'b0010, 1, 0, 50, 1, 4'b0000);
    expect_ev(b + 204, 4'b0010, 1, 0, 0,  1, 4'b0000);
    expect_ev(b + 304, 4'b0010, 1, 0, 0,  2, 4'b0000);
    expect_ev(b + 305, 4'b0000, 0, 0, 0,  2, 4'b0010);
    expect_ev(b + 306, 4'b0000, 0, 0, 0,  2, 4'b0000);
    pulse_req(4'b0010);
    wait_until(b + 310);
    drain();

    // 2: simultaneous req[2]/req[3]; seq2 is done at entry 0
    b = cyc;
    expect_ev(b + 2,   4'b0100, 1, 0, 0,  0, 4'b0000);
    expect_ev(b + 3,   4'b0000, 0, 0, 0,  0, 4'b0100);
    expect_ev(b + 4,   4'b1000, 1, 0, 0,  0, 4'b0000);
    expect_ev(b + 5,   4'b1000, 1, 1, 70, 0, 4'b0000);
    expect_ev(b + 305, 4'b1000, 1, 0, 70, 1, 4'b0000);
    expect_ev(b + 306, 4'b1000, 1, 1, 80, 1, 4'b0000);
    expect_ev(b + 406, 4'b1000, 1, 0, 80, 2, 4'b0000);
    expect_ev(b + 407, 4'b0000, 0, 0, 80, 2, 4'b1000);
    expect_ev(b + 408, 4'b0000, 0, 0, 80, 2, 4'b0000);
    pulse_req(4'b1100);
    wait_until(b + 412);
    drain();

    // 3: req[0] mid-note preempts seq3 only at the note boundary
    b = cyc;
    expect_ev(b + 2,   4'b1000, 1, 0, 80, 0, 4'b0000);
    expect_ev(b + 3,   4'b1000, 1, 1, 70, 0, 4'b0000);
    expect_ev(b + 303, 4'b0001, 1, 0, 70, 0, 4'b0000);
    expect_ev(b + 304, 4'b0001, 1, 1, 30, 0, 4'b0000);
    expect_ev(b + 404, 4'b0001, 1, 0, 30, 1, 4'b0000);
    expect_ev(b + 405, 4'b0000, 0, 0, 30, 1, 4'b0001);
    expect_ev(b + 406, 4'b0000, 0, 0, 30, 1, 4'b0000);
    pulse_req(4'b1000);
    wait_until(b + 50);
    pulse_req(4'b0001);
    wait_until(b + 410);
    drain();

    // 4: cancel owner mid-PLAY, then req+cancel together must not queue
    b = cyc;
    expect_ev(b + 2,  4'b0010, 1, 0, 30, 0, 4'b0000);
    expect_ev(b + 3,  4'b0010, 1, 1, 50, 0, 4'b0000);
    expect_ev(b + 51, 4'b0000, 0, 0, 50, 0, 4'b0000);
    pulse_req(4'b0010);
    wait_until(b + 50);
    pulse_cancel(4'b0010);
    wait_until(b + 60);
    req    = 4'b0010;
    cancel = 4'b0010;
    @(negedge clock);
    req    = '0;
    cancel = '0;
    wait_until(b + 80);
    drain();

    // 5: one-cycle reset mid-note returns everything to reset values
    b = cyc;
    expect_ev(b + 2,  4'b0010, 1, 0, 50, 0, 4'b0000);
    expect_ev(b + 3,  4'b0010, 1, 1, 50, 0, 4'b0000);
    expect_ev(b + 21, 4'b0000, 0, 0, 0,  0, 4'b0000);
    pulse_req(4'b0010);
    wait_until(b + 20);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    wait_until(b + 45);
    drain();

    // 6: sequence done at its first entry, no tone at all
    b = cyc;
    expect_ev(b + 2, 4'b0100, 1, 0, 0, 0, 4'b0000);
    expect_ev(b + 3, 4'b0000, 0, 0, 0, 0, 4'b0100);
    expect_ev(b + 4, 4'b0000, 0, 0, 0, 0, 4'b0000);
    pulse_req(4'b0100);
    wait_until(b + 10);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
